// File: rtl/hex_display_scanner.sv
// hex_display_scanner
// Shows a captured 28-bit count in hex on an 8-digit common-anode 7-segment
// display. One digit is refreshed per prescaler tick. AN, SEG and DP are
// active-low. The AN and SEG pins come straight from registers.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When it is defined, any digit above the highest non-zero nibble is blanked.
//   Digit 0 is always shown.
//   When it is undefined, every digit is shown, including leading zeros.
module hex_display_scanner #(
   parameter int IN_W        = 28,
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000
) (
   input  logic            CLK100MHZ,
   input  logic            CPU_RESETN,
   input  logic [IN_W-1:0] value_in,
   input  logic            load,
   input  logic            blank,
   output logic [7:0]      AN,
   output logic [6:0]      SEG,
   output logic            DP
);

   localparam int VAL_W = 4 * NUM_DIGITS;
   localparam int PW    = $clog2(REFRESH_DIV);

   // The scan state is the index of the digit that the next tick drives.
   typedef enum logic [2:0] {D0, D1, D2, D3, D4, D5, D6, D7} digit_e;

   localparam digit_e LAST_DIGIT = digit_e'(3'(NUM_DIGITS - 1));

   logic [VAL_W-1:0] value_q, value_d;
   logic [VAL_W-1:0] value_ext;
   logic [PW-1:0]    presc_q, presc_d;
   digit_e           digit_q, digit_d;
   logic [7:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             tick;
   logic [2:0]       idx;
   logic [3:0]       nib;
   logic             show;
`ifdef LEADING_ZERO_BLANK_EN
   logic [2:0]       hi_q, hi_d;
`endif

   // Hex to active-low segment decode, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg_dec(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign value_ext = VAL_W'(value_in);
   assign tick      = (presc_q == PW'(REFRESH_DIV - 1));
   assign idx       = digit_q;

   // Select the nibble that belongs to the current scan digit.
   always_comb begin
      nib = 4'h0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == 3'(k)) nib = value_q[4*k +: 4];
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Track the index of the highest non-zero nibble. It is updated on capture, so
   // blanking at tick time only needs one compare.
   always_comb begin
      hi_d = hi_q;
      if (load) begin
         hi_d = 3'd0;
         for (int k = 1; k < NUM_DIGITS; k++) begin
            if (value_ext[4*k +: 4] != 4'h0) hi_d = 3'(k);
         end
      end
   end

   // The digit is lit unless blank is set or the digit is a leading zero.
   always_comb begin
      show = !blank && (idx <= hi_q);
   end
`else
   // The digit is lit unless blank is set.
   always_comb begin
      show = !blank;
   end
`endif

   // Next-state logic for the capture register, prescaler, scan state and pins.
   // On a tick, the digit is decoded from the value held before any same-edge load.
   always_comb begin
      value_d = value_q;
      presc_d = tick ? '0 : presc_q + PW'(1);
      digit_d = digit_q;
      an_d    = an_q;
      seg_d   = seg_q;
      if (load) value_d = value_ext;
      if (tick) begin
         digit_d = (digit_q == LAST_DIGIT) ? D0 : digit_e'(idx + 3'd1);
         if (show) begin
            an_d  = ~(8'b1 << idx);
            seg_d = seg_dec(nib);
         end else begin
            an_d  = 8'hFF;
            seg_d = 7'h7F;
         end
      end
   end

   // State registers. Reset turns the display off at once, and the captured value is lost.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         value_q <= '0;
         presc_q <= '0;
         digit_q <= D0;
         an_q    <= 8'hFF;
         seg_q   <= 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
         hi_q    <= 3'd0;
`endif
      end else begin
         value_q <= value_d;
         presc_q <= presc_d;
         digit_q <= digit_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
`ifdef LEADING_ZERO_BLANK_EN
         hi_q    <= hi_d;
`endif
      end
   end

   assign AN  = an_q;
   assign SEG = seg_q;
   assign DP  = 1'b1;

endmodule
